// File: rtl/d_flip_flop_with_preset_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | d_flip_flop_with_preset_pkg                                      |
// | Shared cell reset value and per-bit next-state function.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package d_flip_flop_with_preset_pkg;

  localparam logic CELL_RESET_VAL = 1'b0;

  // Preset wins over the enable; with neither asserted the cell holds.
  function automatic logic cell_next(input logic preset,
                                     input logic en,
                                     input logic d,
                                     input logic q);
    logic nxt;
    nxt = q;
    if (preset) begin
      nxt = 1'b1;
    end else if (en) begin
      nxt = d;
    end
    return nxt;
  endfunction

endpackage : d_flip_flop_with_preset_pkg
`default_nettype wire

// File: rtl/d_flip_flop_with_preset.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | d_flip_flop_with_preset                                          |
// | Bank of enable-gated D flops with synchronous per-bit preset.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module d_flip_flop_with_preset
  import d_flip_flop_with_preset_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Preset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = cell_next(Preset[i], En, D[i], q_q[i]);
    end
  end

  // Reset overrides every cell regardless of Preset/En.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= {WIDTH{CELL_RESET_VAL}};
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule : d_flip_flop_with_preset
`default_nettype wire

// File: tb/tb_d_flip_flop_with_preset.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench: a 64-bit bank (shift-register style) and a 4-bit bank.
module tb_d_flip_flop_with_preset;

  typedef struct {
    string       name;
    bit          is64;
    logic [63:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst64, en64, shift64;
  logic [63:0] pre64, d64_drv, d64, q64;
  logic        rst4, en4;
  logic [3:0]  pre4, d4, q4;

  // In shift mode D follows the wrapper wiring: bit i takes Q[i-1], bit 0 takes 0.
  assign d64 = shift64 ? {q64[62:0], 1'b0} : d64_drv;

  d_flip_flop_with_preset #(.WIDTH(64)) u_dut64 (
    .Clk(clk), .Reset(rst64), .En(en64), .Preset(pre64), .D(d64), .Q(q64)
  );

  d_flip_flop_with_preset #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset(rst4), .En(en4), .Preset(pre4), .D(d4), .Q(q4)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // Drive one 64-bit vector at the falling edge; the 4-bit bank idles (hold).
  task automatic step64(input string name, input logic r, input logic e,
                        input logic [63:0] p, input logic [63:0] d,
                        input logic sh, input logic [63:0] exp);
    exp_t x;
    @(negedge clk);
    rst64 = r; en64 = e; pre64 = p; d64_drv = d; shift64 = sh;
    rst4 = 1'b0; en4 = 1'b0; pre4 = 4'h0; d4 = 4'h0;
    x.name = name; x.is64 = 1'b1; x.exp = exp;
    sb.push_back(x);
  endtask

  // Drive one 4-bit vector; the 64-bit bank idles (hold).
  task automatic step4(input string name, input logic r, input logic e,
                       input logic [3:0] p, input logic [3:0] d,
                       input logic [3:0] exp);
    exp_t x;
    @(negedge clk);
    rst4 = r; en4 = e; pre4 = p; d4 = d;
    rst64 = 1'b0; en64 = 1'b0; pre64 = '0; d64_drv = '0; shift64 = 1'b0;
    x.name = name; x.is64 = 1'b0; x.exp = {60'h0, exp};
    sb.push_back(x);
  endtask

  // Monitor: each rising edge is an output event for the oldest pending vector.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.is64 ? q64 : {60'h0, q4};
        n_checks++;
        if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    rst64 = 1'b0; en64 = 1'b0; pre64 = '0; d64_drv = '0; shift64 = 1'b0;
    rst4 = 1'b0; en4 = 1'b0; pre4 = 4'h0; d4 = 4'h0;

    // Reset both banks
    step64("reset64", 1'b1, 1'b0, '0, '0, 1'b0, 64'h0);
    step4 ("reset4",  1'b1, 1'b0, 4'h0, 4'h0, 4'h0);

    // Preset load then shift
    step64("preset_load", 1'b0, 1'b0, ONES, '0, 1'b0, ONES);
    step64("shift1", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    step64("shift2", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step64("shift3", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    step64("shift4", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    step64("shift5", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFE0);
    step64("shift_stop", 1'b0, 1'b0, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFE0);

    // Hold with D toggling
    for (int i = 0; i < 4; i++) begin
      step64($sformatf("hold%0d", i), 1'b0, 1'b0, '0, (i % 2 == 0) ? 64'h0 : ONES,
             1'b0, 64'hFFFF_FFFF_FFFF_FFE0);
    end

    // Priority
    step64("rst_over_preset", 1'b1, 1'b1, ONES, ONES, 1'b0, 64'h0);
    step64("preset_over_en",  1'b0, 1'b1, ONES, 64'h0, 1'b0, ONES);
    step64("en_partial_preset", 1'b0, 1'b1, 64'h0000_0000_0000_00F0,
           64'h1234_5678_9ABC_DE01, 1'b0, 64'h1234_5678_9ABC_DEF1);

    // Reset in the middle of shifting
    step64("preset_again", 1'b0, 1'b0, ONES, '0, 1'b0, ONES);
    step64("mid_shift1", 1'b0, 1'b1, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    step64("mid_reset",  1'b1, 1'b1, '0, '0, 1'b1, 64'h0);
    step64("post_reset1", 1'b0, 1'b1, '0, '0, 1'b1, 64'h0);
    step64("post_reset2", 1'b0, 1'b1, '0, '0, 1'b1, 64'h0);

    // Per-bit mix on the 4-bit bank
    step4("mix_preset", 1'b0, 1'b1, 4'b0101, 4'b1010, 4'b1111);
    step4("mix_load",   1'b0, 1'b1, 4'b0000, 4'b0011, 4'b0011);
    step4("mix_hold",   1'b0, 1'b0, 4'b0000, 4'b1100, 4'b0011);
    step4("mix_partial", 1'b0, 1'b0, 4'b1000, 4'b0100, 4'b1011);
    step4("mix_reset",  1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000);

    done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(done && sb.size() == 0) && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d vectors unchecked, required 0", sb.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_d_flip_flop_with_preset
`default_nettype wire
